// File: rtl/dsp_addsub_seq_if.sv
// Handshake bundle for dsp_addsub_seq: operand side and result side.
// master drives operands and out_ready; slave is the arithmetic unit.
interface dsp_addsub_seq_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, result, carry, ovf, zero
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, result, carry, ovf, zero
   );
endinterface

// File: rtl/dsp_addsub_seq.sv
// Sliced add/sub/accumulate unit, SLICE bits per cycle, registered carry.
// Define ADDSUB_SAT_EN to clamp overflowing ADD/SUB/ACC results.
module dsp_addsub_seq #(
   parameter int WIDTH = 32,
   parameter int SLICE = 16
) (
   input logic               clk,
   input logic               rst_n,
   dsp_addsub_seq_if.slave   bus
);
   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_ACC  = 2'b10;
   localparam logic [1:0] OP_LOAD = 2'b11;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             c_q, c_d;
   logic             z_q, z_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;

   logic [SLICE-1:0] xs, ys;
   logic [SLICE:0]   sum;
   logic             last;
   int               idx;

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.result    = res_q;
   assign bus.carry     = carry_q;
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;

   // Next state: operand latch, one slice per BUSY cycle, flags on the last slice.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      c_d     = c_q;
      z_d     = z_q;
      op_d    = op_q;
      x_d     = x_q;
      y_d     = y_q;
      res_d   = res_q;
      acc_d   = acc_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;

      idx  = int'(cnt_q) * SLICE;
      xs   = x_q[idx +: SLICE];
      ys   = y_q[idx +: SLICE];
      sum  = {1'b0, xs} + {1'b0, ys} + {{SLICE{1'b0}}, c_q};
      last = (cnt_q == CW'(NSLICE - 1));

      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               state_d = BUSY;
               cnt_d   = '0;
               z_d     = 1'b1;
               op_d    = bus.op;
               c_d     = (bus.op == OP_SUB);
               unique case (bus.op)
                  OP_ADD:  begin x_d = bus.a;  y_d = bus.b;  end
                  OP_SUB:  begin x_d = bus.a;  y_d = ~bus.b; end
                  OP_ACC:  begin x_d = acc_q;  y_d = bus.a;  end
                  OP_LOAD: begin x_d = '0;     y_d = bus.a;  end
                  default: begin x_d = '0;     y_d = '0;     end
               endcase
            end
         end
         BUSY: begin
            res_d[idx +: SLICE] = sum[SLICE-1:0];
            c_d   = sum[SLICE];
            z_d   = z_q & (sum[SLICE-1:0] == '0);
            cnt_d = cnt_q + 1'b1;
            if (last) begin
               state_d = DONE;
               cnt_d   = '0;
               carry_d = sum[SLICE];
               ovf_d   = (xs[SLICE-1] == ys[SLICE-1]) &&
                         (sum[SLICE-1] != xs[SLICE-1]);
               zero_d  = z_d;
`ifdef ADDSUB_SAT_EN
               // LOAD adds to zero and can never overflow, so no op gate.
               if (ovf_d)
                  res_d = xs[SLICE-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
`endif
               if (op_q[1])
                  acc_d = res_d;
            end
         end
         DONE: begin
            if (bus.out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any in-flight operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         z_q     <= 1'b0;
         op_q    <= OP_ADD;
         x_q     <= '0;
         y_q     <= '0;
         res_q   <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         z_q     <= z_d;
         op_q    <= op_d;
         x_q     <= x_d;
         y_q     <= y_d;
         res_q   <= res_d;
         acc_q   <= acc_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end
endmodule

// File: tb/tb_dsp_addsub_seq.sv
// Bench for dsp_addsub_seq: directed cases plus random ops
// against an arithmetic reference model.
module tb_dsp_addsub_seq;
   localparam int W = 32;
   localparam int NSL = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   logic [W-1:0] acc_m = '0;

   dsp_addsub_seq_if #(.WIDTH(W)) bus ();

   dsp_addsub_seq #(.WIDTH(W), .SLICE(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got,
                        input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model(input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, output logic [W-1:0] r,
                        output logic c, output logic v, output logic z);
      longint ss;
      longint unsigned us;
      case (op)
         2'b00: begin
            us = {32'b0, a} + {32'b0, b};
            ss = longint'(signed'(a)) + longint'(signed'(b));
            c  = us[32];
         end
         2'b01: begin
            ss = longint'(signed'(a)) - longint'(signed'(b));
            c  = (a >= b);
         end
         2'b10: begin
            us = {32'b0, acc_m} + {32'b0, a};
            ss = longint'(signed'(acc_m)) + longint'(signed'(a));
            c  = us[32];
         end
         default: begin
            ss = longint'(signed'(a));
            c  = 1'b0;
         end
      endcase
      r = ss[W-1:0];
      z = (r == '0);
      v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
`ifdef ADDSUB_SAT_EN
      if (v) r = (ss > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
      if (op[1]) acc_m = r;
   endtask

   // Called #1 after a rising edge with the unit idle.
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int hold,
                         input bit poke);
      logic [W-1:0] er;
      logic ec, ev, ez;
      int lat;
      model(op, a, b, er, ec, ev, ez);
      check("in_ready_idle", W'(bus.in_ready), 1);
      bus.out_ready = (hold == 0);
      bus.in_valid  = 1'b1;
      bus.op = op;
      bus.a  = a;
      bus.b  = b;
      @(posedge clk); #1;
      bus.in_valid = poke;
      bus.op = 2'b11;
      bus.a  = $urandom;
      bus.b  = $urandom;
      lat = 0;
      while (!bus.out_valid && lat < 8) begin
         check("in_ready_busy", W'(bus.in_ready), 0);
         @(posedge clk); #1;
         lat++;
      end
      bus.in_valid = 1'b0;
      check("latency", W'(lat), W'(NSL));
      check("result", bus.result, er);
      check("carry", W'(bus.carry), W'(ec));
      check("ovf", W'(bus.ovf), W'(ev));
      check("zero", W'(bus.zero), W'(ez));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_valid", W'(bus.out_valid), 1);
         check("hold_ready", W'(bus.in_ready), 0);
         check("hold_result", bus.result, er);
         check("hold_flags", W'({bus.carry, bus.ovf, bus.zero}),
               W'({ec, ev, ez}));
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("consumed", W'({bus.out_valid, bus.in_ready}), W'(2'b01));
   endtask

   initial begin
      logic [1:0] rop;
      logic [W-1:0] ra, rb;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.op = '0;
      bus.a  = '0;
      bus.b  = '0;
      #12;
      check("rst_in_ready", W'(bus.in_ready), 1);
      check("rst_out_valid", W'(bus.out_valid), 0);
      check("rst_result", bus.result, '0);
      check("rst_flags", W'({bus.carry, bus.ovf, bus.zero}), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      run_op(2'b00, 32'h0000_FFFF, 32'h0000_0001, 0, 0);
      run_op(2'b01, 32'd5, 32'd5, 0, 0);
      run_op(2'b01, 32'd0, 32'd1, 0, 0);
      run_op(2'b00, 32'h7FFF_FFFF, 32'd1, 0, 0);
      run_op(2'b01, 32'h8000_0000, 32'd1, 1, 0);
      run_op(2'b11, 32'd10, 32'd0, 0, 0);
      run_op(2'b10, 32'd3, 32'd0, 0, 1);
      run_op(2'b10, 32'd3, 32'd0, 0, 1);
      run_op(2'b10, 32'd3, 32'd0, 0, 1);
      run_op(2'b00, 32'h1234_5678, 32'h0FED_CBA9, 5, 0);

      bus.in_valid = 1'b1;
      bus.op = 2'b00;
      bus.a  = 32'hFFFF_FFFF;
      bus.b  = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      #2;
      check("midrst_out_valid", W'(bus.out_valid), 0);
      check("midrst_result", bus.result, '0);
      check("midrst_in_ready", W'(bus.in_ready), 1);
      acc_m = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_op(2'b10, 32'd7, 32'd0, 0, 0);

      for (int n = 0; n < 40; n++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         if (n % 5 == 0) ra = 32'h7FFF_FFFF;
         if (n % 7 == 0) rb = ra;
         run_op(rop, ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
